// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the sequential shift-add multiplier.
// Combinational only; no latency or backpressure of its own.
package mult_pkg;

  localparam int OP_WIDTH   = 32;
  localparam int PROD_WIDTH = 64;
  localparam int ITER_COUNT = 32;
  localparam int CNT_WIDTH  = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_addr_32.sv
// 32-bit ripple carry adder, purely combinational (zero latency).
// No handshake; the caller owns all flow control.
module ripple_carry_addr_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_mult_32.sv
// Unsigned 32x32->64 radix-2 shift-add multiplier: accept, 32 RUN cycles, then DONE.
// Product is held in DONE until out_ready; no new operands are taken outside IDLE.
module shift_add_mult_32
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in1,
  input  logic [OP_WIDTH-1:0]   in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROD_WIDTH-1:0] out
);

  state_t                state, next_state;
  logic [OP_WIDTH-1:0]   m, q, a;
  logic                  c;
  logic [CNT_WIDTH-1:0]  count;
  logic [OP_WIDTH-1:0]   addend;
  logic [OP_WIDTH-1:0]   sum;
  logic                  cout;

  assign addend = q[0] ? m : '0;

  ripple_carry_addr_32 u_adder (
    .a    (a),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (count == CNT_WIDTH'(ITER_COUNT - 1)) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      a     <= '0;
      c     <= 1'b0;
      count <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= in1;
            q     <= in2;
            a     <= '0;
            c     <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          // {C,A,Q} <= {cout,sum,Q} >> 1; the carry lands in A's MSB, so C reads back 0.
          c     <= 1'b0;
          a     <= {cout, sum[OP_WIDTH-1:1]};
          q     <= {sum[0], q[OP_WIDTH-1:1]};
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out = {a, q};

endmodule

// File: tb/tb_shift_add_mult_32.sv
// Self-checking bench for shift_add_mult_32: directed vectors, handshake corner cases
// and random operands checked against a plain 64-bit multiply.
module tb_shift_add_mult_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[6];

  shift_add_mult_32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input string nm);
    chk({nm, " in_ready idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in1      = x;
    in2      = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid; expects exactly 32.
  task automatic wait_result(input logic [63:0] exp, input string nm);
    int j;
    j = 0;
    while (!out_valid && j < 60) begin
      @(negedge clk);
      j++;
    end
    chk({nm, " latency"}, 64'(j), 64'd32);
    chk({nm, " product"}, out, exp);
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " in_ready after"}, 64'(in_ready), 64'd1);
    chk({nm, " out_valid after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic        stable;
    logic        seen;
    logic [31:0] rx, ry;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h1234_5678,  32'd0,          64'd0};
    vecs[3] = '{32'd0,          32'h1234_5678,  64'd0};
    vecs[4] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[5] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out", out, 64'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
      wait_result(vecs[i].p, $sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE for 10 cycles with new operands offered.
    start_op(32'd7, 32'd9, "bp");
    wait_result(64'd63, "bp");
    held     = out;
    stable   = 1'b1;
    in_valid = 1'b1;
    in1      = 32'd100;
    in2      = 32'd100;
    repeat (10) begin
      @(negedge clk);
      if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp stable while stalled", 64'(stable), 64'd1);
    chk("bp product held", out, 64'd63);
    release_result("bp");

    // Reset in the middle of RUN aborts the operation.
    start_op(32'd9, 32'd9, "abort");
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort no out_valid", 64'(seen), 64'd0);
    start_op(32'd7, 32'd6, "post_abort");
    wait_result(64'd42, "post_abort");
    release_result("post_abort");

    // in_valid held through RUN/DONE: only taken again once back in IDLE.
    start_op(32'd11, 32'd13, "busy");
    in_valid = 1'b1;
    in1      = 32'd100;
    in2      = 32'd200;
    wait_result(64'd143, "busy first");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("busy idle in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(64'd20000, "busy second");
    release_result("busy second");

    for (int n = 0; n < 20; n++) begin
      rx = $urandom;
      ry = $urandom;
      if (n % 5 == 0) ry = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 31'h7FFF_FFFF};
      start_op(rx, ry, $sformatf("rand%0d", n));
      wait_result(64'(rx) * 64'(ry), $sformatf("rand%0d", n));
      release_result($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
